debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for the stopwatch front panel. It replaces per-button single-channel debounce instances with one block. The block synchronises CHANNELS raw asynchronous button or switch inputs and filters each through its own stability counter. Per channel it presents a clean level plus single-cycle rise and fall pulses, which the stopwatch control FSM consumes directly as start/stop/reset/pause events.

---
 rtl/debounce_multi.sv | 83 ++++++++
 tb/tb_debounce_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Purpose : multi-channel button/switch debouncer with per-channel level and edge pulses.
// Latency : STABLE_CYCLES+2 clk edges from a stable src change to dst/rise/fall.
// Backpressure: none; free-running filter, outputs are plain registered levels/pulses.
//
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset (release is synchronous to clk upstream)
//   src    raw asynchronous inputs, bit i = channel i
//   dst    debounced level per channel
//   rise   one-cycle pulse on the first cycle dst[i] reads 1
//   fall   one-cycle pulse on the first cycle dst[i] reads 0
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] src,
  output logic [CHANNELS-1:0] dst,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // Count value at which a disagreeing input has been stable long enough.
  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0]  s1_q, s2_q;
  logic [CHANNELS-1:0]  dst_q, dst_d;
  logic [CHANNELS-1:0]  rise_q, rise_d;
  logic [CHANNELS-1:0]  fall_q, fall_d;
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];

  // Per-channel filter: any agreement between s2 and dst clears the count,
  // so a bounce restarts qualification with no partial credit.
  always_comb begin
    dst_d  = dst_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == dst_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        dst_d[i]  = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      dst_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      // Two-flop synchroniser; only s2 feeds the filter.
      s1_q   <= src;
      s2_q   <= s1_q;
      dst_q  <= dst_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dst  = dst_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (STABLE_CYCLES = 4 and 1) share one
// stimulus; a history-window reference model predicts dst/rise/fall each cycle.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src = 4'b0000;
  logic [3:0] dst4, rise4, fall4;
  logic [3:0] dst1, rise1, fall1;

  always #5 clk = ~clk;

  debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(4), .CNT_WIDTH(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .src(src), .dst(dst4), .rise(rise4), .fall(fall4)
  );

  debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .src(src), .dst(dst1), .rise(rise1), .fall(fall1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: src values seen at each edge since reset, and the
  // synchronised value that edge presents to the filter (src two edges back).
  logic [3:0] srch[$];
  logic [3:0] s2h[$];
  logic [3:0] m4, m1, er4, ef4, er1, ef1;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // A channel flips when the last s synchronised samples all disagree with its level.
  function automatic logic [3:0] flips(input int s, input logic [3:0] md);
    logic [3:0] f;
    f = '0;
    for (int c = 0; c < 4; c++) begin
      logic ok;
      ok = (s2h.size() >= s);
      if (ok) begin
        for (int j = 0; j < s; j++) begin
          if (s2h[s2h.size() - 1 - j][c] == md[c]) ok = 1'b0;
        end
      end
      f[c] = ok;
    end
    return f;
  endfunction

  task automatic model_clear();
    srch.delete();
    s2h.delete();
    m4 = '0; m1 = '0;
    er4 = '0; ef4 = '0; er1 = '0; ef1 = '0;
  endtask

  // Entered at a negedge: drive src, take one rising edge, update model,
  // compare 1 time unit later, return at the next negedge.
  task automatic tick(input logic [3:0] s);
    logic [3:0] f4, f1, s2;
    src = s;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      srch.push_back(src);
      s2 = (srch.size() >= 3) ? srch[srch.size() - 3] : 4'b0000;
      s2h.push_back(s2);
      if (srch.size() > 16) void'(srch.pop_front());
      if (s2h.size() > 16) void'(s2h.pop_front());
      f4 = flips(4, m4);
      f1 = flips(1, m1);
      er4 = f4 & ~m4; ef4 = f4 & m4; m4 = m4 ^ f4;
      er1 = f1 & ~m1; ef1 = f1 & m1; m1 = m1 ^ f1;
    end
    #1;
    check("dst_s4", dst4, m4);
    check("rise_s4", rise4, er4);
    check("fall_s4", fall4, ef4);
    check("dst_s1", dst1, m1);
    check("rise_s1", rise1, er1);
    check("fall_s1", fall1, ef1);
    @(negedge clk);
  endtask

  // Entered at a negedge: assert reset mid-period, confirm outputs clear
  // before any edge, hold two edges, release at a negedge.
  task automatic mid_reset(input logic [3:0] s);
    src = s;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("areset_dst", dst4 | dst1, 4'b0000);
    check("areset_rise", rise4 | rise1, 4'b0000);
    check("areset_fall", fall4 | fall1, 4'b0000);
    @(negedge clk);
    tick(s);
    tick(s);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    // Reset values with all inputs high, checked before the first edge.
    src = 4'b1111;
    #3;
    check("reset_dst", dst4, 4'b0000);
    check("reset_rise", rise4, 4'b0000);
    check("reset_fall", fall4, 4'b0000);
    @(negedge clk);
    tick(4'b1111);
    rst_n = 1'b1;

    // Inputs high at release: all rise bits pulse together on edge 6.
    for (int k = 0; k < 5; k++) tick(4'b1111);
    check("pre_e6_dst", dst4, 4'b0000);
    tick(4'b1111);
    check("e6_rise_all", rise4, 4'b1111);
    tick(4'b1111);
    check("e7_rise_clear", rise4, 4'b0000);
    check("e7_dst_all", dst4, 4'b1111);

    // Clean falling edge on channel 0: fall pulse exactly 6 edges later.
    for (int k = 0; k < 5; k++) tick(4'b1110);
    check("fall0_early", fall4, 4'b0000);
    tick(4'b1110);
    check("fall0_e6", fall4, 4'b0001);
    tick(4'b1110);
    check("fall0_e7", fall4, 4'b0000);

    // Reset mid-operation, then inputs low.
    mid_reset(4'b0000);
    for (int k = 0; k < 4; k++) tick(4'b0000);

    // Clean rise on ch0 while ch1 bounces 1,1,1,0 and ch2 does 1,1,1,0 then holds.
    begin
      logic [3:0] pat;
      for (int k = 0; k < 8; k++) begin
        pat = 4'b0001;
        pat[1] = (k % 4) != 3;
        pat[2] = (k != 3);
        tick(pat);
        if (k == 5) check("rise0_indep", rise4, 4'b0001);
      end
      check("bounce_dst1", dst4[1] ? 4'b0001 : 4'b0000, 4'b0000);
    end
    // Channel 1 now held high after its final 0->1 at step 8: rise on 6th edge.
    for (int k = 0; k < 5; k++) tick(4'b0111);
    tick(4'b0111);
    check("rise1_after_bounce", rise4 & 4'b0010, 4'b0010);

    // Channel 0 bouncing every cycle while channel 3 rises cleanly.
    mid_reset(4'b0000);
    for (int k = 0; k < 10; k++) tick({1'b1, 2'b00, k[0]});
    check("indep_dst0", dst4 & 4'b0001, 4'b0000);

    // Channel 3 high, reset at its third edge: rise only 6 edges after release.
    mid_reset(4'b0000);
    tick(4'b1000);
    tick(4'b1000);
    mid_reset(4'b1000);
    for (int k = 0; k < 5; k++) tick(4'b1000);
    check("rst3_no_early", rise4, 4'b0000);
    tick(4'b1000);
    check("rst3_rise_e6", rise4, 4'b1000);

    // Randomised: each channel toggles with low probability, occasional resets.
    begin
      logic [3:0] r;
      r = src;
      for (int n = 0; n < 1500; n++) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
        end
        if ($urandom_range(0, 299) == 0) mid_reset(r);
        tick(r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
